// File: rtl/sid_bus_pkg.sv
// Shared SID register-bus definitions: widths, SPI header byte layout and the
// register write entry type.
package sid_bus_pkg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 8;

   localparam int unsigned HDR_BIT = 7;

   localparam int unsigned HDR_ADDR_HI = 6;
   localparam int unsigned HDR_ADDR_LO = 2;
   localparam int unsigned HDR_MSB_HI  = 1;
   localparam int unsigned HDR_MSB_LO  = 0;
   localparam int unsigned DAT_LSB_HI  = 5;
   localparam int unsigned DAT_LSB_LO  = 0;

   localparam int unsigned MSB_W = HDR_MSB_HI - HDR_MSB_LO + 1;
   localparam int unsigned LSB_W = DAT_LSB_HI - DAT_LSB_LO + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } sid_wr_t;

   function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] b);
      return b[HDR_ADDR_HI:HDR_ADDR_LO];
   endfunction

   function automatic logic [MSB_W-1:0] hdr_msbs(input logic [7:0] b);
      return b[HDR_MSB_HI:HDR_MSB_LO];
   endfunction

   // The data byte carries only the low bits; the top bits come from the header.
   function automatic sid_wr_t make_wr(input logic [ADDR_W-1:0] addr,
                                       input logic [MSB_W-1:0]  msbs,
                                       input logic [7:0]        b);
      sid_wr_t w;
      w.addr = addr;
      w.data = {msbs, b[DAT_LSB_HI:DAT_LSB_LO]};
      return w;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extended pointers; a push while full is accepted only
// when a pop happens on the same edge.
module sync_fifo #(
   parameter int unsigned WIDTH = 13,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [AW:0]      level_q;
   logic             full_q, empty_q;
   logic             do_push, do_pop;

   assign do_pop  = pop & ~empty_q;
   assign do_push = push & (~full_q | do_pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= wptr_d - rptr_d;
         // Same slot, different lap: full; same slot, same lap: empty.
         full_q  <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
         empty_q <= (wptr_d == rptr_d);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr_q[AW-1:0]];
   assign full  = full_q;
   assign empty = empty_q;
   assign level = level_q;

endmodule

// File: rtl/sid_write_queue.sv
// Decodes two-byte SPI writes into SID register writes, queues them and issues
// at most one write per SID clock-enable.
module sid_write_queue #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = sid_bus_pkg::ADDR_W,
   parameter int unsigned DATA_W = sid_bus_pkg::DATA_W
) (
   input  logic                       CLK,
   input  logic                       RSTn,
   input  logic [7:0]                 RX_DATA,
   input  logic                       RX_VALID,
   input  logic                       CLKEN,
   output logic                       WR,
   output logic [ADDR_W-1:0]          ADDR,
   output logic [DATA_W-1:0]          DATAW,
   output logic                       FULL,
   output logic                       EMPTY,
   output logic [$clog2(DEPTH):0]     LEVEL,
   output logic                       OVERFLOW,
   output logic                       PROTO_ERR
);

   import sid_bus_pkg::*;

   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
   localparam int unsigned ENT_W = ADDR_W + DATA_W;

   logic                              is_hdr, is_data;
   logic                              push, pop;
   logic                              hdr_valid_q;
   logic [sid_bus_pkg::ADDR_W-1:0]    hdr_addr_q;
   logic [MSB_W-1:0]                  hdr_msb_q;
   sid_wr_t                           dec_wr;
   logic [ENT_W-1:0]                  push_ent, head_ent;
   logic                              fifo_full, fifo_empty;
   logic [LVL_W-1:0]                  fifo_level;
   logic                              wr_q;
   logic [ADDR_W-1:0]                 addr_q;
   logic [DATA_W-1:0]                 dataw_q;
   logic                              overflow_q, proto_err_q;

   assign is_hdr  = RX_VALID &  RX_DATA[HDR_BIT];
   assign is_data = RX_VALID & ~RX_DATA[HDR_BIT];

   assign dec_wr   = make_wr(hdr_addr_q, hdr_msb_q, RX_DATA);
   assign push_ent = {ADDR_W'(dec_wr.addr), DATA_W'(dec_wr.data)};
   assign push     = is_data & hdr_valid_q;
   // Pop decision uses pre-edge EMPTY, so a same-edge push waits for the next enable.
   assign pop      = CLKEN & ~fifo_empty;

   // Header stays latched so repeated data bytes keep hitting the same register.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         hdr_valid_q <= 1'b0;
         hdr_addr_q  <= '0;
         hdr_msb_q   <= '0;
      end else if (is_hdr) begin
         hdr_valid_q <= 1'b1;
         hdr_addr_q  <= hdr_addr(RX_DATA);
         hdr_msb_q   <= hdr_msbs(RX_DATA);
      end
   end

   sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (RSTn),
      .push  (push),
      .pop   (pop),
      .wdata (push_ent),
      .rdata (head_ent),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         dataw_q <= '0;
      end else begin
         wr_q <= pop;
         if (pop) begin
            addr_q  <= head_ent[ENT_W-1:DATA_W];
            dataw_q <= head_ent[DATA_W-1:0];
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         overflow_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         if (push && fifo_full && !pop) overflow_q <= 1'b1;
         if (is_data && !hdr_valid_q)   proto_err_q <= 1'b1;
      end
   end

   assign WR        = wr_q;
   assign ADDR      = addr_q;
   assign DATAW     = dataw_q;
   assign FULL      = fifo_full;
   assign EMPTY     = fifo_empty;
   assign LEVEL     = fifo_level;
   assign OVERFLOW  = overflow_q;
   assign PROTO_ERR = proto_err_q;

   a_full_empty: assert property (@(posedge CLK) disable iff (!RSTn) !(FULL && EMPTY));
   a_level_max:  assert property (@(posedge CLK) disable iff (!RSTn) LEVEL <= LVL_W'(DEPTH));

endmodule

// File: tb/tb_sid_write_queue.sv
// Scoreboard bench for sid_write_queue: a small byte-level model predicts queued
// writes, occupancy and sticky flags; a monitor compares every WR pulse.
module tb_sid_write_queue;

   logic        CLK = 1'b0;
   logic        RSTn = 1'b1;
   logic [7:0]  RX_DATA;
   logic        RX_VALID;
   logic        CLKEN;
   logic        WR;
   logic [4:0]  ADDR;
   logic [7:0]  DATAW;
   logic        FULL, EMPTY;
   logic [4:0]  LEVEL;
   logic        OVERFLOW, PROTO_ERR;

   sid_write_queue #(
      .DEPTH  (16),
      .ADDR_W (5),
      .DATA_W (8)
   ) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .RX_DATA   (RX_DATA),
      .RX_VALID  (RX_VALID),
      .CLKEN     (CLKEN),
      .WR        (WR),
      .ADDR      (ADDR),
      .DATAW     (DATAW),
      .FULL      (FULL),
      .EMPTY     (EMPTY),
      .LEVEL     (LEVEL),
      .OVERFLOW  (OVERFLOW),
      .PROTO_ERR (PROTO_ERR)
   );

   always #5 CLK = ~CLK;

   int          n_err = 0;
   int          n_chk = 0;
   logic [12:0] sb[$];
   int          mlev;
   bit          mov, mpe, hv;
   logic [4:0]  haddr;
   logic [1:0]  hhi;
   int          ccnt;
   bit          auto_ce, man_ce;
   int          wr_count = 0;
   logic        wr_prev = 1'b0;
   int          base;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      mlev = 0;
      mov  = 0;
      mpe  = 0;
      hv   = 0;
      haddr = '0;
      hhi  = '0;
      ccnt = 0;
      sb.delete();
   endtask

   // Drive one cycle of stimulus at the falling edge and advance the model to
   // the state expected after the following rising edge.
   task automatic cycle(input logic v, input logic [7:0] b);
      logic pop, push, acc;
      @(negedge CLK);
      RX_VALID = v;
      RX_DATA  = b;
      if (auto_ce) begin
         CLKEN = (ccnt == 11);
         ccnt  = (ccnt == 11) ? 0 : ccnt + 1;
      end else begin
         CLKEN = man_ce;
      end
      if (RSTn) begin
         pop  = CLKEN && (mlev != 0);
         push = v && !b[7] && hv;
         if (v && !b[7] && !hv) mpe = 1;
         if (v && b[7]) begin
            hv    = 1;
            haddr = b[6:2];
            hhi   = b[1:0];
         end
         acc = push && ((mlev < 16) || pop);
         if (push && !acc) mov = 1;
         if (acc) sb.push_back({haddr, hhi, b[5:0]});
         mlev = mlev + int'(acc) - int'(pop);
      end
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RSTn     = 1'b0;
      RX_VALID = 1'b0;
      CLKEN    = 1'b0;
      auto_ce  = 0;
      man_ce   = 0;
      model_clear();
      repeat (2) @(negedge CLK);
      RSTn = 1'b1;
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      auto_ce = 1;
      while ((mlev != 0) && (n < maxc)) begin
         cycle(1'b0, 8'h00);
         n++;
      end
      cycle(1'b0, 8'h00);
      cycle(1'b0, 8'h00);
      check("drain_bound", 32'(n < maxc), 1);
      check("sb_empty", sb.size(), 0);
   endtask

   always @(posedge CLK) begin : mon
      logic        ce;
      logic [12:0] e;
      ce = CLKEN;
      #1;
      if (RSTn) begin
         if (WR) begin
            wr_count++;
            check("wr_after_clken", ce, 1);
            check("wr_width", wr_prev, 0);
            check("wr_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("addr", ADDR, e[12:8]);
               check("dataw", DATAW, e[7:0]);
            end
         end
         check("level", LEVEL, mlev);
         check("full", FULL, 32'(mlev == 16));
         check("empty", EMPTY, 32'(mlev == 0));
         check("overflow", OVERFLOW, mov);
         check("proto_err", PROTO_ERR, mpe);
      end
      wr_prev = WR;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation bound reached");
      $fatal(1, "timeout");
   end

   initial begin
      RX_DATA  = 8'h00;
      RX_VALID = 1'b0;
      CLKEN    = 1'b0;
      auto_ce  = 0;
      man_ce   = 0;
      model_clear();
      #1 RSTn = 1'b0;
      #2;
      check("rst_wr", WR, 0);
      check("rst_addr", ADDR, 0);
      check("rst_dataw", DATAW, 0);
      check("rst_level", LEVEL, 0);
      check("rst_empty", EMPTY, 1);
      check("rst_full", FULL, 0);
      check("rst_overflow", OVERFLOW, 0);
      check("rst_proto", PROTO_ERR, 0);
      do_reset();

      // Basic write
      auto_ce = 1;
      base = wr_count;
      send(8'h86);
      send(8'h15);
      cycle(1'b0, 8'h00);
      drain(40);
      check("t1_wr_count", wr_count - base, 1);
      check("t1_proto", PROTO_ERR, 0);

      // Header persistence
      do_reset();
      base = wr_count;
      send(8'h86);
      send(8'h15);
      send(8'h3F);
      cycle(1'b0, 8'h00);
      check("t2_level_peak", LEVEL, 2);
      drain(60);
      check("t2_wr_count", wr_count - base, 2);
      check("t2_level_end", LEVEL, 0);
      check("t2_empty_end", EMPTY, 1);

      // Protocol error then recovery
      do_reset();
      base = wr_count;
      send(8'h15);
      cycle(1'b0, 8'h00);
      check("t3_proto", PROTO_ERR, 1);
      check("t3_level", LEVEL, 0);
      auto_ce = 1;
      send(8'h86);
      send(8'h15);
      cycle(1'b0, 8'h00);
      drain(40);
      check("t3_wr_count", wr_count - base, 1);
      check("t3_proto_sticky", PROTO_ERR, 1);

      // Overflow with enables stopped
      do_reset();
      base = wr_count;
      send(8'h80);
      for (int i = 0; i < 17; i++) send(8'(i));
      cycle(1'b0, 8'h00);
      check("t4_level", LEVEL, 16);
      check("t4_full", FULL, 1);
      check("t4_overflow", OVERFLOW, 1);
      drain(16 * 12 + 40);
      check("t4_wr_count", wr_count - base, 16);

      // Full with a pop on the same edge as the push
      do_reset();
      base = wr_count;
      send(8'h80);
      for (int i = 0; i < 16; i++) send(8'(8'h20 + i));
      cycle(1'b0, 8'h00);
      check("t5_full_before", FULL, 1);
      man_ce = 1;
      send(8'h30);
      man_ce = 0;
      cycle(1'b0, 8'h00);
      check("t5_level", LEVEL, 16);
      check("t5_overflow", OVERFLOW, 0);
      drain(16 * 12 + 40);
      check("t5_wr_count", wr_count - base, 17);

      // Random byte stream with free-running enables
      do_reset();
      auto_ce = 1;
      for (int i = 0; i < 80; i++) cycle(1'($urandom_range(0, 1)), 8'($urandom));
      cycle(1'b0, 8'h00);
      drain(16 * 12 + 40);

      // Reset in the middle of a drain
      do_reset();
      send(8'h80);
      for (int i = 0; i < 6; i++) send(8'(8'h40 + i));
      man_ce = 1;
      cycle(1'b0, 8'h00);
      man_ce = 0;
      @(posedge CLK);
      #2;
      check("t6_wr_before", WR, 1);
      check("t6_level_before", LEVEL, 5);
      RSTn = 1'b0;
      #1;
      check("t6_rst_wr", WR, 0);
      check("t6_rst_level", LEVEL, 0);
      check("t6_rst_empty", EMPTY, 1);
      model_clear();
      @(negedge CLK);
      CLKEN = 1'b0;
      RSTn  = 1'b1;
      base  = wr_count;
      auto_ce = 1;
      repeat (30) cycle(1'b0, 8'h00);
      check("t6_no_wr", wr_count - base, 0);
      send(8'h15);
      cycle(1'b0, 8'h00);
      check("t6_proto", PROTO_ERR, 1);
      check("t6_level_after", LEVEL, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/sid_write_queue.md
Name: sid_write_queue

Overview:
Sits between the SPI slave byte receiver and the SID core's register bus. It decodes the two-byte SPI write protocol into (address, data) register writes and buffers them in a FIFO. Writes are issued to the SID one per 1 MHz SID cycle, aligned to the clock-enable. This decouples bursty SPI traffic from the SID timing.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
ADDR_W, 5, SID register address width
DATA_W, 8, SID register data width

Ports:
CLK  in  1  system clock, 12 MHz
RSTn  in  1  asynchronous active-low reset
RX_DATA  in  8  byte from SPI slave
RX_VALID  in  1  one-CLK strobe; RX_DATA is valid
CLKEN  in  1  SID 1 MHz enable, one CLK wide, every 12 CLK
WR  out  1  SID write strobe, one CLK wide
ADDR  out  ADDR_W  SID register address
DATAW  out  DATA_W  SID write data
FULL  out  1  FIFO holds DEPTH entries
EMPTY  out  1  FIFO holds 0 entries
LEVEL  out  clog2(DEPTH)+1  current FIFO occupancy
OVERFLOW  out  1  sticky: a decoded write was dropped because the FIFO was full
PROTO_ERR  out  1  sticky: a data byte arrived with no address latched

Behaviour:
- Reset (RSTn low, asynchronous): WR=0, ADDR=0, DATAW=0, LEVEL=0, EMPTY=1, FULL=0, OVERFLOW=0, PROTO_ERR=0. The FIFO pointers and the header-valid flag are cleared. Reset takes effect immediately, including mid-write or mid-burst.
- Decoder, on RX_VALID with RX_DATA[7]=1 (header byte):
  - Latch addr=RX_DATA[6:2] and hi=RX_DATA[1:0]; set hdr_valid.
  - Nothing is pushed.
- Decoder, on RX_VALID with RX_DATA[7]=0 (data byte):
  - If hdr_valid: push {addr, hi, RX_DATA[5:0]} on the same edge. RX_DATA[6] is ignored.
  - If not hdr_valid: drop the byte and set PROTO_ERR.
- Header persistence: addr, hi and hdr_valid stay latched until the next header byte or reset. Repeated data bytes therefore write the same register.
- Push when FULL with no pop on the same edge: the entry is discarded, OVERFLOW is set, and the FIFO is unchanged.
- Push when FULL with a pop on the same edge: the entry is accepted, LEVEL stays at DEPTH, and OVERFLOW is not set.
- Drain: on a CLK edge where CLKEN=1 and EMPTY=0:
  - Pop the head entry.
  - Register WR=1, ADDR=entry addr, DATAW=entry data.
  - WR returns to 0 on the next edge.
- ADDR and DATAW hold their last values while WR=0.
- Pacing: at most one write per CLKEN pulse. No bypass: an entry pushed on the same edge as a CLKEN pop is not eligible until the next CLKEN.
- Latency: minimum 1 CLK from the push edge to the WR assertion edge, given a CLKEN on the following cycle. Maximum is 12 CLK × (LEVEL before push + 1).
- Simultaneous push and pop on a non-full FIFO: LEVEL unchanged, both take effect.
- FULL, EMPTY and LEVEL are registered and reflect the post-edge state.
- Pointers are clog2(DEPTH)+1 bits and wrap modulo 2·DEPTH. FULL and EMPTY are derived from the MSB comparison.
- OVERFLOW and PROTO_ERR clear only on reset.

Decomposition:
- Shared package sid_bus_pkg:
  - ADDR_W=5, DATA_W=8
  - HDR_BIT=7
  - header field positions: address [6:2], data MSBs [1:0], data LSBs [5:0]
  - packed struct sid_wr_t {addr, data}
- Sub-module sync_fifo: parameterised width and depth, push/pop/full/empty/level, async active-low reset.
- sid_write_queue holds the decoder, the sticky flags and the drain/pacing logic.

Test Plan:
1. Basic write: reset, CLKEN every 12 CLK; send 0x86 then 0x15 -> exactly one WR pulse, 1 CLK wide, one edge after the next CLKEN; ADDR=1, DATAW=0x95; PROTO_ERR=0.
2. Header persistence: send 0x86, 0x15, 0x3F back-to-back -> two WR pulses 12 CLK apart: (1,0x95) then (1,0xBF); LEVEL peaks at 2, then returns to 0 with EMPTY=1.
3. Protocol error: after reset send 0x15 only -> no WR, LEVEL=0, PROTO_ERR=1. Then send 0x86, 0x15 -> normal write (1,0x95); PROTO_ERR remains 1.
4. Overflow: CLKEN held 0; send header 0x80 then 17 data bytes 0x00..0x10 -> LEVEL=16, FULL=1, OVERFLOW=1. Restart CLKEN -> 16 writes to ADDR=0 with DATAW=0x00..0x0F in order; no write of 0x10.
5. Full with simultaneous pop: fill to 16; on the exact edge where CLKEN=1, present a data byte -> entry accepted, LEVEL=16, OVERFLOW=0; the new entry is written 16th after the pop.
6. Reset mid-drain: while WR=1 with LEVEL=5, pulse RSTn low -> WR=0, LEVEL=0, EMPTY=1 immediately; after release, subsequent CLKEN pulses produce no WR until new bytes arrive, and a data byte before any header sets PROTO_ERR.
